// File: rtl/rv32i_dmem_pkg.sv
// Shared types and helpers for the RV32i data-memory responder:
// MMIO register offsets, address-region decode result and byte-lane merging.
package rv32i_dmem_pkg;

    localparam logic [3:0] TIMER_OFF  = 4'h0;
    localparam logic [3:0] TOHOST_OFF = 4'h4;
    localparam logic [3:0] STATUS_OFF = 4'h8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  ble);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = ble[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv32i_byte_ram.sv
// Single-port word RAM with per-byte write enables and a registered,
// read-before-write output that holds between reads.
module rv32i_byte_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [3:0]    ble_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read samples the pre-write word, so a same-cycle write is seen next read.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        if (we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (ble_i[k]) begin
                    mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32i core: word RAM plus a 16-byte MMIO
// window holding a free-running timer, TOHOST and a sticky error flag.
module rv32i_dmem_responder
    import rv32i_dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic        dmem_we_i,
    input  logic        dmem_re_i,
    input  logic [3:0]  dmem_ble_i,
    output logic [31:0] dmem_do_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [29:0] add_w, ram_w, mmio_w;
    logic [3:0]  mmio_off;
    region_e     region;
    logic        ram_we, ram_re;
    logic [31:0] ram_rdata;
    logic        unused_add_lsb;

    logic [31:0] timer_q, timer_d, timer_inc;
    logic [31:0] tohost_data_q, tohost_data_d;
    logic        tohost_valid_q, tohost_valid_d;
    logic        err_q, err_d;
    logic        rd_sel_ram_q, rd_sel_ram_d;
    logic [31:0] rd_other_q, rd_other_d;

    // Decode on word addresses; byte offset bits play no part in the access.
    always_comb begin
        unused_add_lsb = ^dmem_add_i[1:0];
        add_w    = dmem_add_i[31:2];
        ram_w    = add_w - RAM_BASE[31:2];
        mmio_w   = add_w - MMIO_BASE[31:2];
        mmio_off = {mmio_w[1:0], 2'b00};
        if (ram_w[29:AW] == '0) begin
            region = REG_RAM;
        end else if (mmio_w[29:2] == '0) begin
            region = REG_MMIO;
        end else begin
            region = REG_NONE;
        end
        ram_we = dmem_we_i && !reset_i && (region == REG_RAM);
        ram_re = dmem_re_i && !reset_i && (region == REG_RAM);
    end

    rv32i_byte_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .ble_i  (dmem_ble_i),
        .addr_i (ram_w[AW-1:0]),
        .wdata_i(dmem_di_i),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        timer_inc      = timer_q + 32'd1;
        timer_d        = timer_inc;
        tohost_data_d  = tohost_data_q;
        tohost_valid_d = 1'b0;
        err_d          = err_q;
        rd_sel_ram_d   = rd_sel_ram_q;
        rd_other_d     = rd_other_q;

        if (dmem_we_i && region == REG_MMIO) begin
            case (mmio_off)
                TIMER_OFF:  timer_d = lane_merge(timer_inc, dmem_di_i, dmem_ble_i);
                TOHOST_OFF: begin
                    if (dmem_ble_i != 4'b0000) begin
                        tohost_data_d  = lane_merge(tohost_data_q, dmem_di_i, dmem_ble_i);
                        tohost_valid_d = 1'b1;
                    end
                end
                STATUS_OFF: begin
                    if (dmem_ble_i[0] && dmem_di_i[0]) err_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Set after clear so a simultaneous fault keeps the flag raised.
        if ((dmem_we_i || dmem_re_i) && region == REG_NONE) begin
            err_d = 1'b1;
        end

        if (dmem_re_i) begin
            rd_sel_ram_d = (region == REG_RAM);
            rd_other_d   = '0;
            if (region == REG_MMIO) begin
                case (mmio_off)
                    TIMER_OFF:  rd_other_d = timer_q;
                    TOHOST_OFF: rd_other_d = tohost_data_q;
                    STATUS_OFF: rd_other_d = {31'b0, err_q};
                    default:    rd_other_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q        <= '0;
            tohost_data_q  <= '0;
            tohost_valid_q <= 1'b0;
            err_q          <= 1'b0;
            rd_sel_ram_q   <= 1'b0;
            rd_other_q     <= '0;
        end else begin
            timer_q        <= timer_d;
            tohost_data_q  <= tohost_data_d;
            tohost_valid_q <= tohost_valid_d;
            err_q          <= err_d;
            rd_sel_ram_q   <= rd_sel_ram_d;
            rd_other_q     <= rd_other_d;
        end
    end

    assign dmem_do_o      = rd_sel_ram_q ? ram_rdata : rd_other_q;
    assign tohost_valid_o = tohost_valid_q;
    assign tohost_data_o  = tohost_data_q;
    assign err_o          = err_q;

endmodule

// File: doc/rv32i_dmem_responder.md
# rv32i_dmem_responder

Data-memory responder for the RV32i pipeline core: it serves the core's data-memory master port (address, write data, write/read enables, byte-lane enables) from an on-chip word RAM and a small memory-mapped register window. The window holds a free-running cycle timer, a test-termination TOHOST register and a sticky access-error status. It sits beside the core at top level, wired port-for-port to the core's dmem signals.

## Interface
Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two).
- RAM_BASE, 32'h0000_0000, byte base address of RAM (DEPTH_WORDS*4 aligned).
- MMIO_BASE, 32'h1000_0000, byte base address of the 16-byte register window.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- dmem_add_i  in  32  byte address from the core.
- dmem_di_i  in  32  write data from the core, already lane-aligned.
- dmem_we_i  in  1  write strobe.
- dmem_re_i  in  1  read strobe.
- dmem_ble_i  in  4  byte-lane enables; bit k selects bits [8k+7:8k].
- dmem_do_o  out  32  read data returned to the core.
- tohost_valid_o  out  1  one-cycle pulse on a TOHOST write.
- tohost_data_o  out  32  last value written to TOHOST.
- err_o  out  1  sticky access-error flag.

## Operation
- Word index is dmem_add_i[31:2]. dmem_add_i[1:0] is ignored; lanes come only from dmem_ble_i.
- Region decode:
  - RAM when RAM_BASE <= add < RAM_BASE + 4*DEPTH_WORDS.
  - MMIO when MMIO_BASE <= add < MMIO_BASE + 16.
  - Anything else is unmapped.
- MMIO map (byte offsets):
  - 0x0 TIMER, RW. 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0.
  - 0x4 TOHOST, RW. A write latches the enabled lanes and pulses tohost_valid_o. A read returns tohost_data_o.
  - 0x8 STATUS, RW. Bit0 = err; all other bits read 0. Writing 1 to bit0 with lane0 enabled clears err.
  - 0xC reserved. Reads return 0; writes are ignored and raise no error.
- Writes: only enabled lanes change, in RAM, TIMER and TOHOST alike. A write with ble = 4'b0000 is a no-op.
- Reads: always return the full 32-bit word, whatever dmem_ble_i holds.
- Error: we or re on an unmapped address sets err. An unmapped read returns 0 and an unmapped write is dropped.
- Idle (we=0, re=0): dmem_do_o holds its previous value and no state changes except TIMER.

## Timing
- Read latency is one cycle. If re=1 at edge N, dmem_do_o is valid after edge N and holds until the next read edge.
- Writes commit at the edge where we=1.
- re and we in the same cycle at the same address: read-before-write. dmem_do_o returns the old word; the new word is visible to a read the following cycle.
- TIMER write vs. increment in the same cycle: the write wins on enabled lanes. The timer then reads exactly the written value at the next edge, with no +1 that cycle on those lanes. Disabled lanes take the incremented value.
- TIMER read: returns the value before that edge's increment.
- tohost_valid_o: asserted for exactly one cycle after the write edge. Back-to-back writes give back-to-back pulses. tohost_data_o updates on the same edge.
- err_o: asserted after the edge of the faulting access. A new fault in the same cycle as a clear leaves err=1.
- Reset values, applied at the first edge with reset_i=1: dmem_do_o=0, TIMER=0, tohost_data_o=0, tohost_valid_o=0, err_o=0.
- RAM contents are not reset. A write presented while reset_i=1 is discarded.
- Reset mid-operation: a read issued in the reset cycle returns 0, and the pending tohost pulse is cancelled.

## Structure
- Package rv32i_dmem_pkg holds:
  - MMIO offset constants: TIMER_OFF, TOHOST_OFF, STATUS_OFF.
  - Region enum: REG_RAM, REG_MMIO, REG_NONE.
  - A lane-merge function taking (old, new, ble) and returning the merged word.
- Sub-module rv32i_byte_ram: DEPTH_WORDS x 32 synchronous RAM with four byte-write enables and registered read-before-write output.
- The responder instantiates rv32i_byte_ram and adds the decoder, MMIO registers and the output mux. The mux select is registered alongside the read so it aligns with the RAM output.

## Test plan
- Write 0xDEADBEEF to 0x10 with ble=1111, then a read of 0x10 -> dmem_do_o=0xDEADBEEF one cycle after re.
- Write 0x0000_00AA to 0x10 with ble=0001 over 0xDEADBEEF -> the read returns 0xDEADBEAA. Same-cycle re+we to 0x14 -> old data returned, new data on the next read.
- Write 0xFFFF_FFFE to TIMER (0x1000_0000) -> reads on the next two cycles return 0xFFFF_FFFE and 0xFFFF_FFFF, then 0x0000_0000 (wrap).
- Write 0x1 to TOHOST (0x1000_0004) -> tohost_valid_o high for exactly one cycle and tohost_data_o=0x1. Two consecutive writes -> two consecutive pulses.
- Read 0x2000_0000 -> dmem_do_o=0 and err_o=1, which stays set. Write 0x1 to STATUS -> err_o=0. Clear plus a new fault in the same cycle is not possible on a single port; check via a second unmapped access -> err_o=1.
- Assert reset_i during a write to 0x20 -> the RAM word is unchanged, and all outputs are 0 after the edge.
